// File: rtl/rip_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// rip_fetch_pc_gen
//
// Fetch program-counter generator with a direct-mapped branch target buffer.
// The next fetch address is chosen combinationally from a redirect, a stall,
// a BTB-confirmed taken prediction, or sequential pc + 4. It is presented on
// pc_next so the branch predictor's BRAM can start its read. The registered
// pc then lines up with the predictor's 1-cycle-late 'pred' answer.
//
// Ports
//   clk          in   1   clock, all state changes on posedge
//   rstn         in   1   synchronous active-low reset
//   stall        in   1   hold the current fetch pc
//   redirect     in   1   replace the fetch pc with redirect_pc
//   redirect_pc  in  32   corrected fetch address (low 2 bits dropped)
//   pred         in   1   predictor taken bit, aligned with pc
//   btb_we       in   1   write a BTB entry
//   btb_wpc      in  32   branch pc to record
//   btb_wtarget  in  32   branch target to record (low 2 bits dropped)
//   pc_next      out 32   combinational next fetch pc (to predictor)
//   pc           out 32   registered current fetch pc
//   fetch_valid  out  1   pc is a valid fetch this cycle
//   pred_taken   out  1   fetch at pc predicted taken with a BTB hit
//   pred_target  out 32   BTB target for pc (0 on miss)
//   bp_update    out  1   predictor update strobe (fetch_valid & ~stall)
// -----------------------------------------------------------------------------
module rip_fetch_pc_gen #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          BTB_INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        pred,
   input  logic        btb_we,
   input  logic [31:0] btb_wpc,
   input  logic [31:0] btb_wtarget,
   output logic [31:0] pc_next,
   output logic [31:0] pc,
   output logic        fetch_valid,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic        bp_update
);

   localparam int ENTRIES = 1 << BTB_INDEX_BITS;
   localparam int TAG_W   = 32 - BTB_INDEX_BITS - 2;

   typedef enum logic {
      PRIME = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [31:0] pc_reg;

   // ---------------------------------------------------------------------
   // Branch target buffer: valid bits are reset, tag/target storage is not.
   // ---------------------------------------------------------------------
   logic [ENTRIES-1:0]        valid_vec;
   logic [TAG_W-1:0]          tag_mem    [ENTRIES];
   logic [31:0]               target_mem [ENTRIES];

   logic [BTB_INDEX_BITS-1:0] rd_idx;
   logic [TAG_W-1:0]          rd_tag;
   logic [BTB_INDEX_BITS-1:0] wr_idx;
   logic [TAG_W-1:0]          wr_tag;
   logic                      btb_hit;
   logic [31:0]               btb_target;

   assign rd_idx = pc_reg[BTB_INDEX_BITS+1:2];
   assign rd_tag = pc_reg[31:BTB_INDEX_BITS+2];
   assign wr_idx = btb_wpc[BTB_INDEX_BITS+1:2];
   assign wr_tag = btb_wpc[31:BTB_INDEX_BITS+2];

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_valid
         logic valid_reg;

         always_ff @(posedge clk) begin
            if (!rstn) begin
               valid_reg <= 1'b0;
            end else if (btb_we && (wr_idx == BTB_INDEX_BITS'(gi))) begin
               valid_reg <= 1'b1;
            end
         end

         assign valid_vec[gi] = valid_reg;
      end
   endgenerate

   // A write during reset is dropped so a stale tag never pairs with a
   // freshly cleared valid bit.
   always_ff @(posedge clk) begin
      if (rstn && btb_we) begin
         tag_mem[wr_idx]    <= wr_tag;
         target_mem[wr_idx] <= {btb_wtarget[31:2], 2'b00};
      end
   end

   // Lookup is asynchronous on the registered pc; a same-cycle write to the
   // same index only becomes visible after the edge.
   assign btb_hit    = valid_vec[rd_idx] & (tag_mem[rd_idx] == rd_tag);
   assign btb_target = target_mem[rd_idx];

   // ---------------------------------------------------------------------
   // Outputs derived directly from state and lookup
   // ---------------------------------------------------------------------
   assign fetch_valid = rstn & (state_reg == FETCH);
   assign pred_taken  = fetch_valid & pred & btb_hit;
   assign pred_target = (rstn && btb_hit) ? btb_target : 32'h0000_0000;
   assign bp_update   = fetch_valid & ~stall;
   assign pc          = pc_reg;

   // ---------------------------------------------------------------------
   // Next-state and next-pc selection
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      pc_next    = RESET_PC;

      if (!rstn) begin
         state_next = PRIME;
      end else begin
         case (state_reg)
            PRIME: begin
               // One dead cycle so the predictor's BRAM has RESET_PC
               // loaded before the first real fetch.
               state_next = FETCH;
            end
            FETCH: begin
               if (redirect) begin
                  pc_next = {redirect_pc[31:2], 2'b00};
               end else if (stall) begin
                  // Re-present pc so the predictor output stays aligned.
                  pc_next = pc_reg;
               end else if (pred_taken) begin
                  pc_next = btb_target;
               end else begin
                  pc_next = pc_reg + 32'd4;
               end
            end
            default: begin
               state_next = PRIME;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg <= PRIME;
         pc_reg    <= RESET_PC;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

endmodule

// File: tb/tb_rip_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_rip_fetch_pc_gen
//
// Directed scenarios followed by a randomized run. Every cycle the DUT outputs
// are compared with a transaction-level reference model: the BTB is held as an
// associative array of recorded {branch pc, target} pairs keyed by index, and
// the fetch pc follows the published priority rules.
// -----------------------------------------------------------------------------
module tb_rip_fetch_pc_gen;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam int          IB  = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        pred;
   logic        btb_we;
   logic [31:0] btb_wpc;
   logic [31:0] btb_wtarget;
   logic [31:0] pc_next;
   logic [31:0] pc;
   logic        fetch_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        bp_update;

   always #5 clk = ~clk;

   rip_fetch_pc_gen #(
      .RESET_PC       (RPC),
      .BTB_INDEX_BITS (IB)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pred        (pred),
      .btb_we      (btb_we),
      .btb_wpc     (btb_wpc),
      .btb_wtarget (btb_wtarget),
      .pc_next     (pc_next),
      .pc          (pc),
      .fetch_valid (fetch_valid),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .bp_update   (bp_update)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct {
      logic [31:0] wpc;
      logic [31:0] tgt;
   } ent_t;

   ent_t        m_btb [int];
   bit          m_prime    = 1'b1;
   bit          m_pc_known = 1'b0;
   logic [31:0] m_pc       = 32'h0;
   int          cyc        = 0;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) & ((32'd1 << IB) - 32'd1));
   endfunction

   // Drive one cycle of inputs, compare against the model, advance a clock.
   task automatic step(input bit rn, input bit st, input bit rd,
                       input logic [31:0] rdpc, input bit pr, input bit we,
                       input logic [31:0] wpc, input logic [31:0] wt);
      logic [31:0] e_pn;
      logic [31:0] e_tg;
      bit          e_fv;
      bit          e_pt;
      bit          e_bu;
      bit          hit;
      int          ri;

      rstn        = rn;
      stall       = st;
      redirect    = rd;
      redirect_pc = rdpc;
      pred        = pr;
      btb_we      = we;
      btb_wpc     = wpc;
      btb_wtarget = wt;
      #1;

      ri  = idx_of(m_pc);
      hit = m_btb.exists(ri) &&
            ((m_btb[ri].wpc >> (IB + 2)) == (m_pc >> (IB + 2)));

      if (!rn) begin
         e_fv = 0; e_pt = 0; e_bu = 0; e_tg = 32'h0; e_pn = RPC;
      end else if (m_prime) begin
         e_fv = 0; e_pt = 0; e_bu = 0; e_pn = RPC;
         e_tg = hit ? m_btb[ri].tgt : 32'h0;
      end else begin
         e_fv = 1;
         e_pt = pr && hit;
         e_tg = hit ? m_btb[ri].tgt : 32'h0;
         e_bu = !st;
         if (rd)        e_pn = {rdpc[31:2], 2'b00};
         else if (st)   e_pn = m_pc;
         else if (e_pt) e_pn = e_tg;
         else           e_pn = m_pc + 32'd4;
      end

      check_val("pc_next",     pc_next,           e_pn);
      check_val("fetch_valid", {31'd0, fetch_valid}, {31'd0, e_fv});
      check_val("pred_taken",  {31'd0, pred_taken},  {31'd0, e_pt});
      check_val("pred_target", pred_target,       e_tg);
      check_val("bp_update",   {31'd0, bp_update},   {31'd0, e_bu});
      if (m_pc_known) check_val("pc", pc, m_pc);

      $display("cyc %0d rstn=%0d st=%0d rd=%0d pr=%0d we=%0d | pc=%h pc_next=%h fv=%0d pt=%0d tgt=%h",
               cyc, rn, st, rd, pr, we, pc, pc_next, fetch_valid, pred_taken,
               pred_target);

      @(posedge clk);
      cyc++;
      if (!rn) begin
         m_prime    = 1'b1;
         m_pc       = RPC;
         m_pc_known = 1'b1;
         m_btb.delete();
      end else begin
         m_pc    = m_prime ? RPC : e_pn;
         m_prime = 1'b0;
         if (we) m_btb[idx_of(wpc)] = '{wpc, {wt[31:2], 2'b00}};
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit pr);
      step(1, 0, 0, 32'h0, pr, 0, 32'h0, 32'h0);
   endtask

   task automatic redir(input logic [31:0] a);
      step(1, 0, 1, a, 0, 0, 32'h0, 32'h0);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      rstn = 0; stall = 0; redirect = 0; redirect_pc = 0; pred = 0;
      btb_we = 0; btb_wpc = 0; btb_wtarget = 0;
      @(negedge clk);

      // Reset with junk on the inputs; writes must be ignored.
      step(0, 1, 1, 32'h0000_0500, 1, 1, 32'h0000_0100, 32'h0000_0700);
      step(0, 0, 1, 32'h0000_0600, 1, 1, 32'h0000_0104, 32'h0000_0800);

      // PRIME cycle, record 0x108 -> 0x200 at the same time.
      step(1, 0, 0, 32'h0, 0, 1, 32'h0000_0108, 32'h0000_0200);
      check_val("prime_to_reset_pc", pc, 32'h100);
      idle(0);
      check_val("seq_104", pc, 32'h104);
      idle(0);
      check_val("seq_108", pc, 32'h108);

      // BTB hit with pred=1.
      idle(1);
      check_val("hit_next", pc, 32'h200);

      // Same entry, pred=0: fall through.
      redir(32'h108);
      idle(0);
      check_val("nopred_next", pc, 32'h10C);

      // Stall for three cycles at 0x104.
      redir(32'h104);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
         check_val("stall_hold", pc, 32'h104);
      end
      idle(0);
      check_val("stall_release", pc, 32'h108);

      // Redirect while stalled with a predicted-taken hit at 0x108.
      step(1, 1, 1, 32'h0000_3000, 1, 0, 32'h0, 32'h0);
      check_val("redir_over_stall", pc, 32'h3000);

      // Alias: 0x148 overwrites index of 0x108.
      step(1, 0, 0, 32'h0, 0, 1, 32'h0000_0148, 32'h0000_0400);
      redir(32'h108);
      idle(1);
      check_val("alias_miss", pc, 32'h10C);
      redir(32'h148);
      idle(1);
      check_val("alias_hit", pc, 32'h400);

      // Wrap-around, redirect low bits ignored.
      redir(32'hFFFF_FFFF);
      check_val("redir_masked", pc, 32'hFFFF_FFFC);
      idle(1);
      check_val("wrap_zero", pc, 32'h0);

      // Same-cycle write and lookup at the current pc: old contents seen.
      redir(32'h10C);
      step(1, 1, 0, 32'h0, 1, 1, 32'h0000_010C, 32'h0000_0503);
      idle(1);
      check_val("write_then_hit", pc, 32'h500);

      // Mid-run reset with a pending redirect and stall.
      step(0, 1, 1, 32'h0000_2000, 1, 1, 32'h0000_0108, 32'h0000_0200);
      idle(0);
      check_val("rerst_pc0", pc, 32'h100);
      idle(0);
      check_val("rerst_pc1", pc, 32'h104);
      redir(32'h148);
      idle(1);
      check_val("rerst_btb_clear", pc, 32'h14C);

      // Randomized run.
      for (int i = 0; i < 400; i++) begin
         bit          rn;
         logic [31:0] rdpc;
         logic [31:0] wpc;
         rn   = ($urandom_range(0, 63) != 0);
         rdpc = 32'h100 + 32'($urandom_range(0, 255));
         wpc  = 32'h100 + (32'($urandom_range(0, 63)) << 2);
         step(rn, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
              rdpc, 1'($urandom), ($urandom_range(0, 2) == 0), wpc,
              $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
